// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 4;

  // Pulls the addressed byte/half out of a word and extends it; word-sized
  // (and reserved) accesses return the word unchanged.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input size_e       size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: lane_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: lane_extract = {{16{sgn & h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << off;
      SZ_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the right-aligned data lets the byte enables pick the lane.
  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous 32-bit word RAM: byte-enable write, one registered read port.
module dmem_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned/reserved accesses into rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              sgn_q;
  size_e             size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              busy_q;
  logic              ready_q;

  logic              commit;
  logic              fault;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       load_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = (size_q == SZ_RSVD) ||
                 ((size_q == SZ_HALF) && addr_q[0]) ||
                 ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign fault = 1'b0;
`endif

  // The RAM reads the incoming address while idle so the word is already
  // registered by the first WAIT cycle, even for LATENCY=1.
  always_comb begin
    commit    = (state_q == ST_WAIT) && (cnt_q == '0);
    ram_we    = commit && we_q && !fault;
    ram_be    = store_be(size_q, addr_q[1:0]);
    ram_wdata = store_data(size_q, wdata_q);
    ram_addr  = (state_q == ST_IDLE) ? req_addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    load_data = lane_extract(ram_rdata, size_q, addr_q[1:0], sgn_q);
  end

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            size_q  <= size_e'(req_size);
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            cnt_q   <= CNT_LOAD;
            state_q <= ST_WAIT;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (we_q || fault) ? '0 : load_data;
            rsp_err_q   <= fault;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          TMO   = 40;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [int unsigned];

  dmem_responder #(
    .ADDR_W  (AW),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit model_fault(input logic [1:0] size, input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
           (size == 2'd2 && (addr % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int unsigned idx;
    idx = (addr / 4) % DEPTH;
    return mem_m.exists(idx) ? mem_m[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit sgn,
                                             input logic [31:0] addr);
    logic [31:0] w, v;
    int unsigned sh;
    w = model_word(addr);
    if (size == 2'd0) begin
      sh = 8 * (addr % 4);
      v  = (w >> sh) & 32'hFF;
      if (sgn && v > 127) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      sh = 16 * ((addr / 2) % 2);
      v  = (w >> sh) & 32'hFFFF;
      if (sgn && v > 32767) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] wd);
    logic [31:0] w, mask;
    int unsigned sh;
    w = model_word(addr);
    if (size == 2'd0) begin
      sh   = 8 * (addr % 4);
      mask = 32'hFF << sh;
      w    = (w & ~mask) | ((wd & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh   = 16 * ((addr / 2) % 2);
      mask = 32'hFFFF << sh;
      w    = (w & ~mask) | ((wd & 32'hFFFF) << sh);
    end else begin
      w = wd;
    end
    mem_m[(addr / 4) % DEPTH] = w;
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic do_txn(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < TMO) begin
      @(posedge clk); #1; w++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < TMO) begin
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, rsp_valid, rsp_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/rsp_valid/rsp_err got %b expected 000", {busy, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic test_directed();
    vec_t        v [$];
    logic [31:0] r;
    logic        e;
    int          lat;
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h00000000, "sw_100"});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, "lw_100"});
    v.push_back('{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'hFFFFFFDE, "lb_103"});
    v.push_back('{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h000000DE, "lbu_103"});
    v.push_back('{1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        32'hFFFFBEEF, "lh_100"});
    v.push_back('{1'b1, 2'd0, 1'b0, 32'h101, 32'h55,       32'h00000000, "sb_101"});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEAD55EF, "lw_100_after_sb"});
    foreach (v[i]) begin
      do_txn(v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wd, r, e, lat);
      if (v[i].we) model_store(v[i].size, v[i].addr, v[i].wd);
      checks++;
      if (r !== v[i].exp) begin
        errors++;
        $display("FAIL %s rdata: got %h expected %h", v[i].name, r, v[i].exp);
      end
      checks++;
      if (e !== 1'b0) begin
        errors++;
        $display("FAIL %s err: got %b expected 0", v[i].name, e);
      end
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] r;
    logic        e;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk); #1;
    // next request is held pending for the whole backpressured response
    req_we = 1'b0; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h102;
    lat = 0;
    while (!rsp_valid && lat < TMO) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid, req_ready, busy} !== 3'b101 || rsp_rdata !== 32'hDEAD55EF) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid/ready/busy %b rdata %h expected 101 DEAD55EF",
                 c, {rsp_valid, req_ready, busy}, rsp_rdata);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_no_same_cycle_accept: valid/ready/busy got %b expected 010",
               {rsp_valid, req_ready, busy});
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_next: busy got %b expected 1", busy);
    end
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < TMO) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT || rsp_rdata !== 32'h0000DEAD || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_rsp: lat %0d rdata %h err %b expected %0d 0000DEAD 0",
               lat, rsp_rdata, rsp_err, LAT);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, r, e, lat);
    checks++;
    if (r !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL bp_ignored_changes: lw 100 got %h expected DEAD55EF", r);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] r;
    logic        e;
    int          lat;
    do_txn(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, r, e, lat);
    model_store(2'd2, 32'h200, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_inflight_flags: valid/busy got %b expected 00", {rsp_valid, busy});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight_ready: ready/valid got %b%b expected 10", req_ready, rsp_valid);
    end
    do_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, r, e, lat);
    checks++;
    if (r !== 32'hCAFEF00D || lat != LAT) begin
      errors++;
      $display("FAIL rst_inflight_mem: lw 200 got %h lat %0d expected CAFEF00D lat %0d", r, lat, LAT);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] r, exp_w;
    logic        e;
    int          lat;
    bit          f;
    f = model_fault(2'd2, 32'h102);
    do_txn(1'b1, 2'd2, 1'b0, 32'h102, 32'hA5A5A5A5, r, e, lat);
    if (!f) model_store(2'd2, 32'h102, 32'hA5A5A5A5);
    checks++;
    if (r !== 32'h0 || e !== f || lat != LAT) begin
      errors++;
      $display("FAIL misalign_sw: rdata %h err %b lat %0d expected 00000000 %b %0d", r, e, lat, f, LAT);
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_w = 32'hDEAD55EF;
`else
    exp_w = 32'hA5A5A5A5;
`endif
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, r, e, lat);
    checks++;
    if (r !== exp_w) begin
      errors++;
      $display("FAIL misalign_mem: lw 100 got %h expected %h", r, exp_w);
    end
    f = model_fault(2'd1, 32'h101);
    do_txn(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, r, e, lat);
    checks++;
    if (r !== (f ? 32'h0 : model_load(2'd1, 1'b1, 32'h101)) || e !== f) begin
      errors++;
      $display("FAIL misalign_lh: rdata %h err %b expected %h %b",
               r, e, f ? 32'h0 : model_load(2'd1, 1'b1, 32'h101), f);
    end
    f = model_fault(2'd3, 32'h100);
    do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, r, e, lat);
    checks++;
    if (r !== (f ? 32'h0 : model_load(2'd3, 1'b0, 32'h100)) || e !== f) begin
      errors++;
      $display("FAIL reserved_size: rdata %h err %b expected %h %b",
               r, e, f ? 32'h0 : model_load(2'd3, 1'b0, 32'h100), f);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, wd, exp_r;
    logic        e;
    logic [1:0]  sz;
    bit          we, sgn, f;
    int          lat;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_txn(1'b1, 2'd2, 1'b0, 32'h300 + 4 * i, wd, r, e, lat);
      model_store(2'd2, 32'h300 + 4 * i, wd);
    end
    for (int i = 0; i < 80; i++) begin
      we  = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      sgn = $urandom_range(0, 1);
      wd  = $urandom;
      a   = 32'h300 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3) + ($urandom_range(0, 255) << 12);
      f   = model_fault(sz, a);
      exp_r = (we || f) ? 32'h0 : model_load(sz, sgn, a);
      do_txn(we, sz, sgn, a, wd, r, e, lat);
      if (we && !f) model_store(sz, a, wd);
      checks++;
      if (r !== exp_r || e !== f || lat != LAT) begin
        errors++;
        $display("FAIL random #%0d we=%0d size=%0d sgn=%0d addr=%h: rdata %h err %b lat %0d expected %h %b %0d",
                 i, we, sz, sgn, a, r, e, lat, exp_r, f, LAT);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_inflight();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits (depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to rsp_valid (legal 1..15).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  MEM-stage request present.
REQ-006 SHALL have port req_ready  out  1  responder can accept.
REQ-007 SHALL have port req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_signed  in  1  sign-extend load (lb/lh) vs zero-extend (lbu/lhu).
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  MEM stage takes response.
REQ-014 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores.
REQ-015 SHALL have port rsp_err  out  1  access fault (see Configuration).
REQ-016 SHALL have port busy  out  1  high whenever not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-018 SHALL, on req_valid&&req_ready, capture all req_* fields, load counter with LATENCY-1, enter WAIT.
REQ-019 SHALL, in WAIT, decrement counter each cycle; in the cycle counter==0 perform the access and enter RESP (LATENCY=1: single WAIT cycle).
REQ-020 SHALL assert rsp_valid in RESP with rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE; no new request accepted in that same cycle.
REQ-021 SHALL index memory with addr[ADDR_W+1:2]; higher address bits ignored (wrap-around).
REQ-022 SHALL select byte lane addr[1:0] for bytes, half lane addr[1] for halves (lane 0 = bits 7:0).
REQ-023 SHALL store by writing wdata[7:0]/[15:0]/[31:0] into the selected lane(s) via byte enables, other bytes unchanged.
REQ-024 SHALL extend loaded byte/half per req_signed to 32 bits.
REQ-025 SHALL return read-after-write data: a load following a store to the same word sees the new value.
REQ-026 SHALL ignore req_* changes while not IDLE.

Reset
REQ-027 SHALL on rst force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0; req_ready 1 once rst deasserts.
REQ-028 SHALL drop an in-flight request on rst; a store not yet at its commit cycle SHALL NOT modify memory.
REQ-029 SHALL NOT reset memory contents.

Configuration
REQ-030 SHALL honour macro DMEM_MISALIGN_TRAP_EN.
REQ-031 SHALL, with macro defined, flag misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0) or size=11: no memory write, rsp_rdata=0, rsp_err=1, same LATENCY.
REQ-032 SHALL, without macro, tie rsp_err to 0, ignore addr[0] for halves, addr[1:0] for words, treat size=11 as word.

Structure
REQ-033 SHALL place size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding and lane-extract function in shared package dmem_pkg.
REQ-034 SHALL instantiate one sub-module dmem_ram: synchronous 32-bit word array with 4-bit byte-enable write and one read port.

Verification
REQ-035 SHALL test: reset, store word 0xDEADBEEF to 0x100, load word 0x100 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly LATENCY cycles after accept.
REQ-036 SHALL test: then lb 0x103 signed -> 0xFFFFFFDE; lbu 0x103 -> 0x000000DE; lh 0x100 signed -> 0xFFFFBEEF.
REQ-037 SHALL test: sb 0x55 to 0x101 then lw 0x100 -> 0xDEAD55EF.
REQ-038 SHALL test: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata stable, req_ready 0 throughout; accept next request only after handshake.
REQ-039 SHALL test: assert rst during WAIT of store 0x12345678 to 0x200 -> rsp_valid 0, later lw 0x200 returns prior contents.
REQ-040 SHALL test with DMEM_MISALIGN_TRAP_EN: sw to 0x102 -> rsp_err 1, rdata 0, memory unchanged; without macro same store writes word 0x100.
